// File: rtl/game_pkg.sv
// Shared constants and encodings for the block-tracking game logic.
package game_pkg;

    localparam int unsigned N_BLOCKS      = 50;
    localparam logic [3:0]  INIT_HEALTH   = 4'd3;
    localparam logic [7:0]  INVULN_FRAMES = 8'd60;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Downstream game_state encoding; a simultaneous win and loss resolves to GS_WIN there.
    typedef enum logic [1:0] {
        GS_IDLE = 2'b00,
        GS_PLAY = 2'b01,
        GS_WIN  = 2'b11,
        GS_LOSE = 2'b10
    } game_state_e;

endpackage

// File: rtl/invuln_timer.sv
// Damage-immunity countdown: loads on damage, counts frames down to zero, busy while nonzero.
module invuln_timer #(
    parameter logic [7:0] LOAD_VAL = game_pkg::INVULN_FRAMES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic load,
    input  logic tick,
    output logic busy
);

    logic [7:0] r_count;

    // NOTE: every flop is written with <= so all registers sample pre-edge values together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            // A load on the same cycle as a frame tick wins over the decrement.
            r_count <= LOAD_VAL;
        end else if (tick && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign busy = (r_count != 8'd0);

endmodule

// File: rtl/block_tracker.sv
// Tracks which level blocks the player has touched, remaining health and the damage-immunity window.
module block_tracker #(
    parameter int unsigned N_BLOCKS      = game_pkg::N_BLOCKS,
    parameter logic [3:0]  INIT_HEALTH   = game_pkg::INIT_HEALTH,
    parameter logic [7:0]  INVULN_FRAMES = game_pkg::INVULN_FRAMES
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                frame_tick,
    input  logic                hit_valid,
    input  logic [5:0]          hit_idx,
    input  logic                dmg,
    output logic [N_BLOCKS-1:0] bk_touched,
    output logic [3:0]          health,
    output logic [5:0]          touched_cnt,
    output logic                hit_new,
    output logic                idx_err,
    output logic                invuln
);

    import game_pkg::*;

    localparam logic [6:0]          LP_N_IDX = 7'(N_BLOCKS);
    localparam logic [5:0]          LP_N_CNT = 6'(N_BLOCKS);
    localparam logic [N_BLOCKS-1:0] LP_ONE   = {{(N_BLOCKS-1){1'b0}}, 1'b1};

    state_e              r_state;
    logic [N_BLOCKS-1:0] r_bk_touched;
    logic [3:0]          r_health;
    logic [5:0]          r_touched_cnt;
    logic                r_hit_new;
    logic                r_idx_err;

    logic                w_play;
    logic                w_idx_ok;
    logic [N_BLOCKS-1:0] w_hit_mask;
    logic                w_hit_fresh;
    logic                w_busy;
    logic                w_dmg_take;
    logic                w_restart;
    logic [N_BLOCKS-1:0] w_bk_next;
    logic [5:0]          w_cnt_next;
    logic [3:0]          w_health_next;
    logic                w_game_over;

    assign w_play      = (r_state == ST_PLAY);
    assign w_idx_ok    = ({1'b0, hit_idx} < LP_N_IDX);
    assign w_hit_mask  = LP_ONE << hit_idx;
    assign w_hit_fresh = w_play && hit_valid && w_idx_ok && ((r_bk_touched & w_hit_mask) == '0);
    assign w_dmg_take  = w_play && dmg && !w_busy && (r_health != 4'd0);
    assign w_restart   = start && !w_play;

    assign w_bk_next     = w_hit_fresh ? (r_bk_touched | w_hit_mask) : r_bk_touched;
    assign w_cnt_next    = r_touched_cnt + 6'(w_hit_fresh);
    assign w_health_next = r_health - 4'(w_dmg_take);
    // Win and loss on the same edge both stay visible; downstream decides the priority.
    assign w_game_over   = (w_cnt_next == LP_N_CNT) || (w_health_next == 4'd0);

    invuln_timer #(
        .LOAD_VAL (INVULN_FRAMES)
    ) u_invuln_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_restart),
        .load    (w_dmg_take),
        .tick    (frame_tick && w_play),
        .busy    (w_busy)
    );

    // NOTE: bk_touched is a plain flop vector, not a memory, so it takes the async reset with the rest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_bk_touched  <= '0;
            r_health      <= INIT_HEALTH;
            r_touched_cnt <= '0;
            r_hit_new     <= 1'b0;
            r_idx_err     <= 1'b0;
        end else begin
            r_hit_new <= w_hit_fresh;
            r_idx_err <= hit_valid && !w_idx_ok;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    r_bk_touched  <= w_bk_next;
                    r_touched_cnt <= w_cnt_next;
                    r_health      <= w_health_next;
                    if (w_game_over) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_bk_touched  <= '0;
                        r_touched_cnt <= '0;
                        r_health      <= INIT_HEALTH;
                        r_state       <= ST_PLAY;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bk_touched  = r_bk_touched;
    assign health      = r_health;
    assign touched_cnt = r_touched_cnt;
    assign hit_new     = r_hit_new;
    assign idx_err     = r_idx_err;
    assign invuln      = w_busy;

endmodule

// File: tb/tb_block_tracker.sv
// Randomised scoreboard bench for block_tracker against a set/counter-level game model.
module tb_block_tracker;

    localparam int NB     = 50;
    localparam int INIT_H = 3;
    localparam int FRAMES = 60;
    localparam logic [NB-1:0] ALL_ONES = '1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          frame_tick = 1'b0;
    logic          hit_valid = 1'b0;
    logic [5:0]    hit_idx = '0;
    logic          dmg = 1'b0;
    logic [NB-1:0] bk_touched;
    logic [3:0]    health;
    logic [5:0]    touched_cnt;
    logic          hit_new;
    logic          idx_err;
    logic          invuln;

    block_tracker dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .frame_tick  (frame_tick),
        .hit_valid   (hit_valid),
        .hit_idx     (hit_idx),
        .dmg         (dmg),
        .bk_touched  (bk_touched),
        .health      (health),
        .touched_cnt (touched_cnt),
        .hit_new     (hit_new),
        .idx_err     (idx_err),
        .invuln      (invuln)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] bk;
        logic [3:0]    health;
        logic [5:0]    cnt;
        logic          hn;
        logic          ie;
        logic          inv;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   act_hn = 0;
    int   act_ie = 0;

    // Reference model: a set of touched blocks, a life count, a frame countdown and an in-game flag.
    bit   m_touched[NB];
    int   m_health;
    int   m_immune;
    bit   m_active;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < NB; i++) c += int'(m_touched[i]);
        return c;
    endfunction

    function automatic logic [NB-1:0] model_vec();
        logic [NB-1:0] v = '0;
        for (int i = 0; i < NB; i++) v[i] = m_touched[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NB; i++) m_touched[i] = 1'b0;
        m_health = INIT_H;
        m_immune = 0;
    endtask

    task automatic model_step(input bit s, input bit t, input bit hv, input int idx, input bit d,
                              output exp_t e);
        bit hn = 1'b0;
        if (m_active) begin
            if (hv && idx < NB && !m_touched[idx]) begin
                m_touched[idx] = 1'b1;
                hn = 1'b1;
            end
            if (d && m_immune == 0 && m_health > 0) begin
                m_health = m_health - 1;
                m_immune = FRAMES;
            end else if (t && m_immune > 0) begin
                m_immune = m_immune - 1;
            end
            if (model_count() == NB || m_health == 0) m_active = 1'b0;
        end else if (s) begin
            model_clear();
            m_active = 1'b1;
        end
        e.bk     = model_vec();
        e.health = 4'(m_health);
        e.cnt    = 6'(model_count());
        e.hn     = hn;
        e.ie     = hv && (idx >= NB);
        e.inv    = (m_immune > 0);
    endtask

    task automatic step(input bit s, input bit t, input bit hv, input int idx, input bit d);
        exp_t e;
        @(negedge clk);
        start      = s;
        frame_tick = t;
        hit_valid  = hv;
        hit_idx    = 6'(idx);
        dmg        = d;
        model_step(s, t, hv, idx, d, e);
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic rand_step();
        bit s  = ($urandom_range(0, 47) == 0);
        bit t  = ($urandom_range(0, 3) == 0);
        bit hv = ($urandom_range(0, 1) == 1);
        int ix = ($urandom_range(0, 7) == 0) ? int'($urandom_range(NB, 63)) : int'($urandom_range(0, NB - 1));
        bit d  = ($urandom_range(0, 11) == 0);
        step(s, t, hv, ix, d);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bk"},      64'(bk_touched),  64'(0));
        check({tag, "_health"},  64'(health),      64'(INIT_H));
        check({tag, "_cnt"},     64'(touched_cnt), 64'(0));
        check({tag, "_hit_new"}, 64'(hit_new),     64'(0));
        check({tag, "_idx_err"}, 64'(idx_err),     64'(0));
        check({tag, "_invuln"},  64'(invuln),      64'(0));
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear before any clock edge.
    task automatic reset_mid_cycle();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        m_active = 1'b0;
        model_clear();
        start = 1'b1; hit_valid = 1'b1; hit_idx = 6'd3; dmg = 1'b1; frame_tick = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("held_reset");
        start = 1'b0; hit_valid = 1'b0; hit_idx = '0; dmg = 1'b0; frame_tick = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: pops one expectation per clock edge that the driver issued stimulus for.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("bk_touched",  64'(bk_touched),  64'(mon_e.bk));
                check("health",      64'(health),      64'(mon_e.health));
                check("touched_cnt", 64'(touched_cnt), 64'(mon_e.cnt));
                check("hit_new",     64'(hit_new),     64'(mon_e.hn));
                check("idx_err",     64'(idx_err),     64'(mon_e.ie));
                check("invuln",      64'(invuln),      64'(mon_e.inv));
                if (hit_new) act_hn++;
                if (idx_err) act_ie++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_hn;
        int base_ie;
        m_active = 1'b0;
        model_clear();

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Idle: hits and damage ignored, range errors still flagged.
        step(1'b0, 1'b1, 1'b1, 5, 1'b1);
        step(1'b0, 1'b0, 1'b1, 55, 1'b0);
        idle(2);

        // Full clear of all blocks in order.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        base_hn = act_hn;
        for (int i = 0; i < NB; i++) step(1'b0, ($urandom_range(0, 2) == 0), 1'b1, i, 1'b0);
        idle(2);
        check("win_hit_new_pulses", 64'(act_hn - base_hn), 64'(NB));
        check("win_bk_all_ones",    64'(bk_touched),       64'(ALL_ONES));
        check("win_touched_cnt",    64'(touched_cnt),      64'(NB));
        step(1'b0, 1'b1, 1'b1, 3, 1'b1);
        idle(1);
        check("done_health_frozen", 64'(health), 64'(INIT_H));

        // Restart from DONE, then a repeated hit.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        base_hn = act_hn;
        step(1'b0, 1'b0, 1'b1, 7, 1'b0);
        step(1'b0, 1'b0, 1'b1, 7, 1'b0);
        idle(1);
        check("dup_touched_cnt", 64'(touched_cnt),      64'(1));
        check("dup_hit_new",     64'(act_hn - base_hn), 64'(1));

        // Out-of-range indices.
        base_ie = act_ie;
        step(1'b0, 1'b0, 1'b1, 50, 1'b0);
        step(1'b0, 1'b0, 1'b1, 63, 1'b0);
        idle(1);
        check("oor_idx_err_pulses", 64'(act_ie - base_ie), 64'(2));
        check("oor_bk_unchanged",   64'(bk_touched),       64'(1) << 7);

        // Damage, ignored damage inside the immunity window, damage after it expires.
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);
        idle(1);
        check("dmg1_health", 64'(health), 64'(2));
        check("dmg1_invuln", 64'(invuln), 64'(1));
        repeat (10) step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);
        idle(1);
        check("dmg2_ignored", 64'(health), 64'(2));
        repeat (61) step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(1);
        check("immunity_expired", 64'(invuln), 64'(0));
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);
        idle(1);
        check("dmg3_health", 64'(health), 64'(1));

        // Last life and last block lost/won on the same cycle.
        repeat (FRAMES) step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < NB - 1; i++) step(1'b0, 1'b0, 1'b1, i, 1'b0);
        step(1'b0, 1'b0, 1'b1, NB - 1, 1'b1);
        idle(1);
        check("tie_health_zero", 64'(health),      64'(0));
        check("tie_bk_all_ones", 64'(bk_touched),  64'(ALL_ONES));
        check("tie_cnt",         64'(touched_cnt), 64'(NB));
        step(1'b0, 1'b1, 1'b1, 4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(1);
        check("restart_health", 64'(health),     64'(INIT_H));
        check("restart_bk",     64'(bk_touched), 64'(0));

        // Random play with restarts.
        repeat (1500) rand_step();

        // Reset in the middle of a game.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 11, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);
        reset_mid_cycle();
        step(1'b0, 1'b0, 1'b1, 12, 1'b1);
        repeat (300) rand_step();

        @(negedge clk);
        start = 1'b0; frame_tick = 1'b0; hit_valid = 1'b0; dmg = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
